// File: rtl/bch_error_correct.sv
// Error-correction stage behind the BCH error locator: buffers raw data words and XORs the err stream onto them.
// Optional macro BCH_CORRECT_COUNT_EN adds an err_count output with the per-codeword corrected-bit popcount.
module bch_error_correct #(
  parameter int DATA_BITS  = 5,
  parameter int BITS       = 1,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] data_in,
  input  logic            data_valid,
  input  logic            err_first,
  input  logic [BITS-1:0] err,
  output logic [BITS-1:0] out_data,
  output logic            out_valid,
  output logic            out_first,
  output logic            out_last,
  output logic            overflow,
  output logic            underflow,
  output logic            sync_err
`ifdef BCH_CORRECT_COUNT_EN
  ,
  output logic [$clog2(DATA_BITS+1)-1:0] err_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WORDS = (DATA_BITS + BITS - 1) / BITS;
  localparam int REM   = DATA_BITS % BITS;
  localparam int CNT_W = (WORDS < 2) ? 1 : $clog2(WORDS + 1);

  localparam logic [CNT_W-1:0]      WORDS_C  = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [DEPTH_LOG2:0]   OCC_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   OCC_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic {IDLE, CORRECT} state_t;

  logic [BITS-1:0] last_mask;

  // The final word carries only the DATA_BITS remainder bits (all of them when the split is exact).
  genvar gi;
  generate
    for (gi = 0; gi < BITS; gi++) begin : g_mask
      assign last_mask[gi] = (REM == 0) || (gi < REM);
    end
  endgenerate

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BITS-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, wr_ptr_q;
  logic [DEPTH_LOG2:0]   occ_q, occ_d;

  logic [BITS-1:0] out_data_q;
  logic            out_valid_q, out_first_q, out_last_q;
  logic            overflow_q, underflow_q, sync_err_q;

  logic            active, empty, full, push, pop;
  logic            word_first, word_last, sync_set;
  logic [CNT_W-1:0] word_idx;
  logic [BITS-1:0] cur_mask, head_eff, applied_err, out_word;

  assign active = (state_q == CORRECT) || err_first;
  assign empty  = (occ_q == '0);
  assign full   = (occ_q == OCC_FULL);
  assign pop    = active && !empty;
  assign push   = data_valid && (!full || pop);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_idx   = '0;
    sync_set   = 1'b0;
    word_first = 1'b0;
    word_last  = 1'b0;
    if (state_q == IDLE) begin
      if (err_first) word_idx = CNT_ONE;
    end else begin
      word_idx = cnt_q + CNT_ONE;
      // A resync mid-codeword restarts the count; on the final word it simply chains the next codeword.
      if (err_first && (word_idx != WORDS_C)) begin
        word_idx = CNT_ONE;
        sync_set = 1'b1;
      end
    end
    if (active) begin
      word_first = (word_idx == CNT_ONE);
      word_last  = (word_idx == WORDS_C);
      if (word_last) begin
        cnt_d   = '0;
        state_d = ((state_q == CORRECT) && err_first) ? CORRECT : IDLE;
      end else begin
        cnt_d   = word_idx;
        state_d = CORRECT;
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + OCC_ONE;
    else if (pop && !push) occ_d = occ_q - OCC_ONE;
  end

  // An empty buffer contributes zeros, so the err word passes straight through.
  assign cur_mask    = word_last ? last_mask : {BITS{1'b1}};
  assign head_eff    = pop ? mem[rd_ptr_q] : '0;
  assign applied_err = err & cur_mask;
  assign out_word    = (head_eff ^ err) & cur_mask;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      occ_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      occ_q       <= occ_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      out_data_q  <= active ? out_word : '0;
      out_valid_q <= active;
      out_first_q <= active && word_first;
      out_last_q  <= active && word_last;
      overflow_q  <= overflow_q  || (data_valid && full && !pop);
      underflow_q <= underflow_q || (active && empty);
      sync_err_q  <= sync_err_q  || sync_set;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign sync_err  = sync_err_q;

`ifdef BCH_CORRECT_COUNT_EN
  localparam int EC_W = $clog2(DATA_BITS + 1);

  logic [EC_W-1:0] acc_q, err_count_q, acc_sum;

  function automatic logic [EC_W-1:0] popcnt(input logic [BITS-1:0] v);
    logic [EC_W-1:0] c;
    c = '0;
    for (int i = 0; i < BITS; i++) c = c + EC_W'(v[i]);
    return c;
  endfunction

  assign acc_sum = (word_first ? '0 : acc_q) + popcnt(applied_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      err_count_q <= '0;
    end else if (active) begin
      if (word_last) begin
        acc_q       <= '0;
        err_count_q <= acc_sum;
      end else begin
        acc_q <= acc_sum;
      end
    end
  end

  assign err_count = err_count_q;
`else
  logic unused_applied;
  assign unused_applied = ^applied_err;
`endif

endmodule

// File: tb/tb_bch_error_correct.sv
// Scoreboard bench: instance A (16 data bits, 4-bit words) and B (5 data bits, 2-bit words), both 4-deep.
module tb_bch_error_correct;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] a_din, a_err, a_out;
  logic       a_dv, a_ef, a_ov, a_of, a_ol, a_ovf, a_unf, a_syn;
  logic [1:0] b_din, b_err, b_out;
  logic       b_dv, b_ef, b_ov, b_of, b_ol, b_ovf, b_unf, b_syn;
`ifdef BCH_CORRECT_COUNT_EN
  logic [4:0] a_cnt;
  logic [2:0] b_cnt;
`endif

  bch_error_correct #(.DATA_BITS(16), .BITS(4), .DEPTH_LOG2(2)) u_a (
    .clk(clk), .rst_n(rst_n), .data_in(a_din), .data_valid(a_dv), .err_first(a_ef), .err(a_err),
    .out_data(a_out), .out_valid(a_ov), .out_first(a_of), .out_last(a_ol),
    .overflow(a_ovf), .underflow(a_unf), .sync_err(a_syn)
`ifdef BCH_CORRECT_COUNT_EN
    , .err_count(a_cnt)
`endif
  );

  bch_error_correct #(.DATA_BITS(5), .BITS(2), .DEPTH_LOG2(2)) u_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_din), .data_valid(b_dv), .err_first(b_ef), .err(b_err),
    .out_data(b_out), .out_valid(b_ov), .out_first(b_of), .out_last(b_ol),
    .overflow(b_ovf), .underflow(b_unf), .sync_err(b_syn)
`ifdef BCH_CORRECT_COUNT_EN
    , .err_count(b_cnt)
`endif
  );

  typedef struct {
    logic [3:0] data;
    logic       first;
    logic       last;
    int         cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic a_cyc(input logic dv, input logic [3:0] din, input logic ef, input logic [3:0] e);
    @(negedge clk);
    a_dv = dv; a_din = din; a_ef = ef; a_err = e;
  endtask

  task automatic b_cyc(input logic dv, input logic [1:0] din, input logic ef, input logic [1:0] e);
    @(negedge clk);
    b_dv = dv; b_din = din; b_ef = ef; b_err = e;
  endtask

  task automatic a_exp(input logic [3:0] d, input logic f, input logic l, input int c);
    exp_t x;
    x.data = d; x.first = f; x.last = l; x.cnt = c;
    qa.push_back(x);
  endtask

  task automatic b_exp(input logic [3:0] d, input logic f, input logic l, input int c);
    exp_t x;
    x.data = d; x.first = f; x.last = l; x.cnt = c;
    qb.push_back(x);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    a_dv = 0; a_ef = 0; a_err = 0; a_din = 0;
    b_dv = 0; b_ef = 0; b_err = 0; b_din = 0;
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (a_ov) begin
      if (qa.size() == 0) check("a_unexpected_out", 1, 0);
      else begin
        ea = qa.pop_front();
        $display("A out data=0x%0h first=%0b last=%0b", a_out, a_of, a_ol);
        check("a_data", a_out, ea.data);
        check("a_first", a_of, ea.first);
        check("a_last", a_ol, ea.last);
`ifdef BCH_CORRECT_COUNT_EN
        if (ea.last) check("a_err_count", a_cnt, ea.cnt);
`endif
      end
    end
    if (b_ov) begin
      if (qb.size() == 0) check("b_unexpected_out", 1, 0);
      else begin
        eb = qb.pop_front();
        $display("B out data=0x%0h first=%0b last=%0b", b_out, b_of, b_ol);
        check("b_data", b_out, eb.data);
        check("b_first", b_of, eb.first);
        check("b_last", b_ol, eb.last);
`ifdef BCH_CORRECT_COUNT_EN
        if (eb.last) check("b_err_count", b_cnt, eb.cnt);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_dv = 0; a_din = 0; a_ef = 0; a_err = 0;
    b_dv = 0; b_din = 0; b_ef = 0; b_err = 0;
    repeat (3) @(negedge clk);
    check("rst_a_valid", a_ov, 0);
    check("rst_a_flags", {a_ovf, a_unf, a_syn}, 0);
    check("rst_b_valid", b_ov, 0);
    rst_n = 1'b1;
    idle(1);

    // B: masking of the 1-bit final word
    for (int k = 0; k < 3; k++) b_cyc(1, 2'h3, 0, 0);
    b_exp(4'h3, 1, 0, 0); b_cyc(0, 0, 1, 2'h0);
    b_exp(4'h3, 0, 0, 0); b_cyc(0, 0, 0, 2'h0);
    b_exp(4'h0, 0, 1, 1); b_cyc(0, 0, 0, 2'h3);
    for (int k = 0; k < 3; k++) b_cyc(1, 2'h3, 0, 0);
    b_exp(4'h3, 1, 0, 0); b_cyc(0, 0, 1, 2'h0);
    b_exp(4'h3, 0, 0, 0); b_cyc(0, 0, 0, 2'h0);
    b_exp(4'h1, 0, 1, 0); b_cyc(0, 0, 0, 2'h2);
    for (int k = 0; k < 3; k++) b_cyc(1, 2'h3, 0, 0);
    b_exp(4'h2, 1, 0, 0); b_cyc(0, 0, 1, 2'h1);
    b_exp(4'h1, 0, 0, 0); b_cyc(0, 0, 0, 2'h2);
    b_exp(4'h1, 0, 1, 2); b_cyc(0, 0, 0, 2'h0);
    idle(2);
    check("b_drain", qb.size(), 0);
    check("b_flags", {b_ovf, b_unf, b_syn}, 0);

    // A: basic correction
    for (int k = 1; k <= 4; k++) a_cyc(1, 4'(k), 0, 0);
    a_exp(4'h1, 1, 0, 0); a_cyc(0, 0, 1, 4'h0);
    a_exp(4'hA, 0, 0, 0); a_cyc(0, 0, 0, 4'h8);
    a_exp(4'h3, 0, 0, 0); a_cyc(0, 0, 0, 4'h0);
    a_exp(4'h5, 0, 1, 2); a_cyc(0, 0, 0, 4'h1);
    idle(2);
    check("a_t1_drain", qa.size(), 0);
    check("a_t1_flags", {a_ovf, a_unf, a_syn}, 0);

    // A: overflow on the 5th push, readout keeps the first 4
    for (int k = 6; k <= 9; k++) a_cyc(1, 4'(k), 0, 0);
    a_cyc(1, 4'hA, 0, 0);
    check("a_ovf_before_5th", a_ovf, 0);
    idle(1);
    check("a_ovf_after_5th", a_ovf, 1);
    a_exp(4'h6, 1, 0, 0); a_cyc(0, 0, 1, 0);
    a_exp(4'h7, 0, 0, 0); a_cyc(0, 0, 0, 0);
    a_exp(4'h8, 0, 0, 0); a_cyc(0, 0, 0, 0);
    a_exp(4'h9, 0, 1, 0); a_cyc(0, 0, 0, 0);
    idle(2);
    check("a_t3_drain", qa.size(), 0);
    check("a_t3_unf_syn", {a_unf, a_syn}, 0);

    // A: resync on word 3, then err_first coinciding with the final word
    for (int k = 1; k <= 4; k++) a_cyc(1, 4'(k), 0, 0);
    a_exp(4'h1, 1, 0, 0); a_cyc(1, 4'h5, 1, 0);
    a_exp(4'h2, 0, 0, 0); a_cyc(1, 4'h6, 0, 0);
    a_exp(4'h3, 1, 0, 0); a_cyc(1, 4'h7, 1, 0);
    a_exp(4'h4, 0, 0, 0); a_cyc(0, 0, 0, 0);
    a_exp(4'h5, 0, 0, 0); a_cyc(0, 0, 0, 0);
    a_exp(4'h6, 0, 1, 0); a_cyc(0, 0, 1, 0);
    a_exp(4'h6, 1, 0, 0); a_cyc(1, 4'h8, 0, 4'h1);
    a_exp(4'h8, 0, 0, 0); a_cyc(1, 4'h9, 0, 0);
    a_exp(4'h9, 0, 0, 0); a_cyc(1, 4'hA, 0, 0);
    a_exp(4'hA, 0, 1, 1); a_cyc(0, 0, 0, 0);
    idle(2);
    check("a_t5_drain", qa.size(), 0);
    check("a_t5_sync", a_syn, 1);
    check("a_t5_unf", a_unf, 0);
    check("a_t5_ovf_sticky", a_ovf, 1);

    // A: empty-buffer underflow passes err through
    a_exp(4'h6, 1, 0, 0); a_cyc(0, 0, 1, 4'h6);
    a_exp(4'h5, 0, 0, 0); a_cyc(0, 0, 0, 4'h5);
    a_exp(4'h0, 0, 0, 0); a_cyc(0, 0, 0, 4'h0);
    a_exp(4'h3, 0, 1, 6); a_cyc(0, 0, 0, 4'h3);
    idle(2);
    check("a_t4_drain", qa.size(), 0);
    check("a_t4_unf", a_unf, 1);

    // A: async reset mid-codeword
    for (int k = 1; k <= 4; k++) a_cyc(1, 4'(k), 0, 0);
    a_exp(4'h1, 1, 0, 0); a_cyc(0, 0, 1, 0);
    a_exp(4'h2, 0, 0, 0); a_cyc(0, 0, 0, 0);
    @(negedge clk);
    a_dv = 0; a_ef = 0; a_err = 0;
    check("a_valid_pre_rst", a_ov, 1);
    rst_n = 1'b0;
    #1;
    check("a_valid_in_rst", a_ov, 0);
    check("a_flags_in_rst", {a_ovf, a_unf, a_syn}, 0);
    check("a_t6_drain", qa.size(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a_cyc(1, 4'hC, 0, 0); a_cyc(1, 4'hD, 0, 0); a_cyc(1, 4'hE, 0, 0); a_cyc(1, 4'hF, 0, 0);
    a_exp(4'h3, 1, 0, 0); a_cyc(0, 0, 1, 4'hF);
    a_exp(4'hD, 0, 0, 0); a_cyc(0, 0, 0, 4'h0);
    a_exp(4'hF, 0, 0, 0); a_cyc(0, 0, 0, 4'h1);
    a_exp(4'hD, 0, 1, 6); a_cyc(0, 0, 0, 4'h2);
    idle(3);
    check("a_post_rst_drain", qa.size(), 0);
    check("a_post_rst_flags", {a_ovf, a_unf, a_syn}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bch_error_correct.md
Name: bch_error_correct

Overview:
- Stage directly downstream of bch_error_one.
- Buffers raw codeword data words as they arrive.
- Consumes the error-locator stream (err_first plus one err word per cycle) and XORs each err word onto the matching buffered data word.
- Emits corrected data with first/last framing and sticky fault flags.

Parameters:
- DATA_BITS, 5: data bits per codeword being corrected.
- BITS, 1: bits per word, for both data and err; must match the error locator's BITS.
- DEPTH_LOG2, 4: log2 of buffer depth in words; DEPTH = 2**DEPTH_LOG2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  BITS  raw data word, oldest bit first in the same order the locator emits err.
- data_valid  in  1  push data_in into the buffer this cycle.
- err_first  in  1  first err word of a codeword; the locator's "first" output.
- err  in  BITS  error mask word.
- out_data  out  BITS  corrected word.
- out_valid  out  1  out_data valid.
- out_first  out  1  first word of codeword.
- out_last  out  1  last word of codeword.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop required while empty.
- sync_err  out  1  sticky: err_first seen mid-codeword.

Behaviour:
- Reset (async, rst_n=0) clears all of the following:
  - every output;
  - buffer pointers and occupancy;
  - word counter;
  - state to IDLE.
- Buffer contents need no reset.
- WORDS = ceil(DATA_BITS/BITS). LAST_MASK keeps the low (DATA_BITS mod BITS) bits of the final word, or all bits if the remainder is 0.
- Buffer: circular FIFO, DEPTH entries, occupancy counter of width DEPTH_LOG2+1.
- Push when data_valid.
  - Full and no pop in the same cycle: the word is dropped and overflow is set.
  - Full with a simultaneous pop: the push is accepted.
- FSM, two states:
  - IDLE: err ignored unless err_first=1. On err_first: pop, word counter=1, go to CORRECT, and register an output with out_first=1.
  - CORRECT: every cycle, pop one word and register an output; err is sampled regardless of value.
    - When word counter reaches WORDS, set out_last on that word and return to IDLE.
    - If the err_first cycle is also word WORDS (WORDS=1), stay in IDLE with first and last both set.
  - err_first while in CORRECT before the final word:
    - set sync_err;
    - abandon the old codeword with no out_last for it;
    - treat the cycle as word 1 of a new codeword (out_first=1, counter=1).
  - err_first coinciding with the final word: the final word completes normally with out_last=1. The same cycle then starts a new codeword rather than going to IDLE. sync_err is not set.
- Output word = (fifo_head ^ err), ANDed with LAST_MASK on the final word, else unmasked.
- Latency: outputs registered exactly 1 cycle after the err word is sampled.
  - out_valid stays high for WORDS consecutive cycles per codeword.
  - out_first/out_last are single-cycle pulses qualified by out_valid.
- Pop while empty (data not yet arrived):
  - underflow is set;
  - out_data = err (masked on the last word);
  - out_valid is still asserted;
  - occupancy stays at 0 and pointers do not move.
  - A push in that same cycle is stored, not bypassed.
- Pointers wrap modulo DEPTH. Occupancy never exceeds DEPTH nor goes below 0.
- Sticky flags clear only on reset.
- Asserting reset mid-codeword aborts immediately. The first err_first after release starts cleanly.

Optional Feature:
- Macro BCH_CORRECT_COUNT_EN.
- When defined:
  - adds output err_count, width $clog2(DATA_BITS+1);
  - it holds the popcount of all err bits applied to the current codeword, after masking;
  - it is updated together with out_last, held until the next out_last, and reset to 0.
- When undefined: the port and counting logic are absent. All other behaviour is identical.

Test Plan:
1. DATA_BITS=16, BITS=4: push 0x1,0x2,0x3,0x4; then err_first with err 0x0,0x8,0x0,0x1 on consecutive cycles.
   -> out_data 0x1,0xA,0x3,0x5 one cycle after each err; first on word 1, last on word 4; flags 0; err_count=2.
2. DATA_BITS=5, BITS=2: push 0x3,0x3,0x3; err 0x0,0x0,0x3.
   -> outputs 0x3,0x3,0x0 with last masked; err 0x2 on the last word gives 0x1 (0x3^0x2=0x1, masked 0x1).
3. DEPTH_LOG2=2: push 5 words with no pops.
   -> overflow=1 after the 5th push; later readout yields words 1-4 only.
4. err_first with an empty buffer and err=0x6.
   -> out_data=0x6, out_valid=1, underflow=1.
5. DATA_BITS=16, BITS=4: err_first again on word 3 of a codeword.
   -> sync_err=1, out_first on that word, no out_last for the aborted codeword; err_first on word 4 gives out_last and a new out_first next cycle, with sync_err unchanged.
6. Deassert rst_n mid-CORRECT.
   -> out_valid=0 and flags=0 immediately; a subsequent codeword corrects correctly.
